mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Sequences and shares the single external memory port (memory_addr/rden/wren/read_val/write_val/response) between the instruction-fetch requester and the data-memory requester. It accepts one transaction at a time, drives the port from registered state, and waits for memory_response. It returns read data plus a one-cycle done pulse to the owning requester and aborts stuck accesses on timeout. It sits between the fetch/data units of the datapath and the memory interface.

Parameters:
DATA_PRIO, 1, 1 = data requester wins simultaneous requests; 0 = fetch wins
TIMEOUT, 255, cycles in ACCESS without response before abort (8-bit counter; 0 disables timeout)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
if_req  input  1  fetch request (level)
if_addr  input  32  fetch address
if_rdata  output  32  fetched word
if_done  output  1  fetch complete, one-cycle pulse
d_req  input  1  data request (level)
d_we  input  1  1 = write, 0 = read
d_addr  input  32  data address
d_wdata  input  32  write data
d_rdata  output  32  read word
d_done  output  1  data complete, one-cycle pulse
err  output  1  qualifies done pulse: 1 = timed out
busy  output  1  high in ACCESS and DONE states
memory_addr  output  32  port address
memory_rden  output  1  port read enable
memory_wren  output  1  port write enable
memory_write_val  output  32  port write data
memory_read_val  input  32  port read data
memory_response  input  1  port completion strobe

Behaviour:
- Reset (sync, active-high, overrides everything, including mid-access): state IDLE. All outputs 0. Both armed bits = 1. Timeout counter = 0. An in-flight access is dropped with no done pulse.
- States: IDLE, ACCESS, DONE.
- Armed bit per requester: cleared when that requester's done pulses; set in any cycle its req is sampled low. A request is eligible only when req=1 and armed=1, so a held-high req never retriggers.
- IDLE: if any requester is eligible, choose it (DATA_PRIO decides ties). Latch addr, wdata and we (fetch: we=0, wdata=0) and the owner id, then go to ACCESS. memory_rden/wren go high on the next cycle, registered.
- ACCESS: memory_addr = latched addr. memory_rden = !we, memory_wren = we. memory_write_val = latched wdata on writes, else 0.
  - On memory_response=1: capture memory_read_val into owner's rdata (reads only; writes leave rdata unchanged). Go to DONE.
  - Otherwise increment the counter. If TIMEOUT≠0 and the counter reaches TIMEOUT: go to DONE with err flagged and owner rdata set to 0.
- DONE (one cycle): rden/wren/addr/write_val = 0. Owner's done = 1. err = the timeout flag. Clear the counter. Return to IDLE. No new grant is made in DONE.
- Minimum latency: request eligible at cycle 0 → rden high at cycle 1 → response at cycle 1 → done at cycle 2. An N-cycle memory gives done at cycle N+1.
- memory_response in IDLE or DONE is ignored.
- Requester inputs are sampled only at grant. Changes during ACCESS have no effect.
- rdata holds its value until that requester's next completion.
- Non-owner done is always 0. err is 0 whenever both dones are 0.
- Only one of memory_rden/memory_wren is ever high.

Test Plan:
- Fetch read: if_req=1, if_addr=0x10, response 3 cycles after rden with read_val=0x8C220004 → rden high at cycles 1-3, if_rdata=0x8C220004, if_done pulse at cycle 4, err=0.
- Simultaneous: if_req=d_req=1 with DATA_PRIO=1, d_we=0, d_addr=0x40 → data served first (addr 0x40), then fetch. Two done pulses, data before fetch, separated by at least one IDLE cycle.
- Write: d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF, response after 1 cycle → memory_wren=1, memory_write_val=0xDEADBEEF, rden=0, d_done pulse, d_rdata unchanged.
- Held request: if_req held high for 20 cycles, response always after 1 cycle → exactly one fetch. After if_req drops for one cycle and rises again, a second fetch occurs.
- Timeout: TIMEOUT=4, no response → rden high 4 cycles, then if_done=1 with err=1, if_rdata=0, rden=0. Next request proceeds normally.
- Reset mid-access: reset asserted in cycle 2 of ACCESS → next cycle all outputs 0, no done pulse. A stray response afterwards is ignored. A new request is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one external memory port between the instruction-fetch requester
//   and the data requester. One transaction is in flight at a time. The port
//   is driven from registered state. The owner gets its read data and a
//   one-cycle done pulse. An access that never sees memory_response is
//   aborted after TIMEOUT cycles.
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   if_req/if_addr          fetch request (level) and address
//   if_rdata/if_done        fetched word, one-cycle completion pulse
//   d_req/d_we/d_addr/...   data request, write flag, address, write data
//   d_rdata/d_done          data read word, one-cycle completion pulse
//   err                     qualifies a done pulse: 1 = access timed out
//   busy                    high while an access is in ACCESS or DONE
//   memory_*                external memory port
//
// Parameters
//   DATA_PRIO  1 = data requester wins simultaneous requests, 0 = fetch wins
//   TIMEOUT    ACCESS cycles without response before abort (0 = never)
module mem_port_arbiter #(
  parameter int unsigned DATA_PRIO = 1,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        err,
  output logic        busy,
  output logic [31:0] memory_addr,
  output logic        memory_rden,
  output logic        memory_wren,
  output logic [31:0] memory_write_val,
  input  logic [31:0] memory_read_val,
  input  logic        memory_response
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  state_t     state;
  logic       owner_d;     // 1 = data requester owns the access
  logic       if_armed;
  logic       d_armed;
  logic [7:0] cnt;

  logic       if_elig;
  logic       d_elig;
  logic       pick_d;
  logic       grant_we;
  logic [7:0] cnt_inc;
  logic       timed_out;
  logic       to_done;

  always_comb begin
    if_elig   = if_req & if_armed;
    d_elig    = d_req & d_armed;
    pick_d    = d_elig & (~if_elig | (DATA_PRIO != 0));
    grant_we  = pick_d & d_we;
    cnt_inc   = cnt + 8'd1;
    timed_out = (TIMEOUT != 0) && (cnt_inc == TIMEOUT_CNT);
    to_done   = memory_response | timed_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      owner_d          <= 1'b0;
      if_armed         <= 1'b1;
      d_armed          <= 1'b1;
      cnt              <= '0;
      if_rdata         <= '0;
      d_rdata          <= '0;
      if_done          <= 1'b0;
      d_done           <= 1'b0;
      err              <= 1'b0;
      busy             <= 1'b0;
      memory_addr      <= '0;
      memory_rden      <= 1'b0;
      memory_wren      <= 1'b0;
      memory_write_val <= '0;
    end else begin
      // A low request re-arms; the done pulse disarms a still-held request
      // so it cannot be granted a second time.
      if (!if_req)      if_armed <= 1'b1;
      else if (if_done) if_armed <= 1'b0;
      if (!d_req)       d_armed  <= 1'b1;
      else if (d_done)  d_armed  <= 1'b0;

      if_done <= 1'b0;
      d_done  <= 1'b0;
      err     <= 1'b0;

      case (state)
        IDLE: begin
          if (if_elig || d_elig) begin
            owner_d          <= pick_d;
            memory_addr      <= pick_d ? d_addr : if_addr;
            memory_rden      <= ~grant_we;
            memory_wren      <= grant_we;
            memory_write_val <= grant_we ? d_wdata : '0;
            cnt              <= '0;
            busy             <= 1'b1;
            state            <= ACCESS;
          end
        end

        ACCESS: begin
          if (to_done) begin
            // Response wins over a coincident timeout; memory_wren still
            // holds the latched write flag here.
            if (memory_response) begin
              if (!memory_wren) begin
                if (owner_d) d_rdata  <= memory_read_val;
                else         if_rdata <= memory_read_val;
              end
            end else begin
              if (owner_d) d_rdata  <= '0;
              else         if_rdata <= '0;
            end
            if (owner_d) d_done  <= 1'b1;
            else         if_done <= 1'b1;
            err              <= ~memory_response;
            memory_addr      <= '0;
            memory_rden      <= 1'b0;
            memory_wren      <= 1'b0;
            memory_write_val <= '0;
            state            <= DONE;
          end else begin
            cnt <= cnt_inc;
          end
        end

        DONE: begin
          cnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        err;
  logic        busy;
  logic [31:0] memory_addr;
  logic        memory_rden;
  logic        memory_wren;
  logic [31:0] memory_write_val;
  logic [31:0] memory_read_val;
  logic        memory_response;

  int errors = 0;
  int checks = 0;

  // Reference model: last completed value per requester.
  logic [31:0] m_if_rdata;
  logic [31:0] m_d_rdata;

  logic [69:0] port_obs;
  assign port_obs = {memory_addr, memory_rden, memory_wren, memory_write_val,
                     busy, if_done, d_done, err};

  mem_port_arbiter #(.DATA_PRIO(1), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .err(err), .busy(busy),
    .memory_addr(memory_addr), .memory_rden(memory_rden),
    .memory_wren(memory_wren), .memory_write_val(memory_write_val),
    .memory_read_val(memory_read_val), .memory_response(memory_response)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // Expected port/status tuple in the same order as port_obs.
  function automatic logic [69:0] pk(input logic [31:0] a, input logic rd,
                                     input logic wr, input logic [31:0] wv,
                                     input logic bz, input logic ifd,
                                     input logic dd, input logic er);
    return {a, rd, wr, wv, bz, ifd, dd, er};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; if_req = 0; d_req = 0; d_we = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    memory_read_val = '0; memory_response = 0;
    tick; tick;
    checks++; if (port_obs !== '0) begin errors++; $display("FAIL reset_port got %h exp 0", port_obs); end
    checks++; if ({if_rdata, d_rdata} !== 64'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", {if_rdata, d_rdata}); end
    reset = 1'b0;
    tick;
    checks++; if (port_obs !== '0) begin errors++; $display("FAIL post_reset_idle got %h exp 0", port_obs); end
    m_if_rdata = '0; m_d_rdata = '0;
  endtask

  task automatic test_fetch_read;
    if_req = 1; if_addr = 32'h10; memory_read_val = 32'h8C220004;
    tick;
    for (int unsigned c = 1; c <= 3; c++) begin
      checks++; if (port_obs !== pk(32'h10, 1, 0, 0, 1, 0, 0, 0)) begin errors++; $display("FAIL fetch_access c%0d got %h exp %h", c, port_obs, pk(32'h10, 1, 0, 0, 1, 0, 0, 0)); end
      memory_response = (c == 3);
      tick;
    end
    m_if_rdata = 32'h8C220004;
    checks++; if (port_obs !== pk(0, 0, 0, 0, 1, 1, 0, 0)) begin errors++; $display("FAIL fetch_done got %h exp %h", port_obs, pk(0, 0, 0, 0, 1, 1, 0, 0)); end
    checks++; if (if_rdata !== m_if_rdata) begin errors++; $display("FAIL fetch_rdata got %h exp %h", if_rdata, m_if_rdata); end
    if_req = 0; memory_response = 0;
    tick;
    checks++; if (port_obs !== '0) begin errors++; $display("FAIL fetch_idle got %h exp 0", port_obs); end
  endtask

  task automatic test_simultaneous;
    if_req = 1; if_addr = 32'h44; d_req = 1; d_we = 0; d_addr = 32'h40;
    tick;
    checks++; if (port_obs !== pk(32'h40, 1, 0, 0, 1, 0, 0, 0)) begin errors++; $display("FAIL simul_data_first got %h exp %h", port_obs, pk(32'h40, 1, 0, 0, 1, 0, 0, 0)); end
    memory_response = 1; memory_read_val = 32'h11112222;
    tick;
    m_d_rdata = 32'h11112222;
    checks++; if (port_obs !== pk(0, 0, 0, 0, 1, 0, 1, 0)) begin errors++; $display("FAIL simul_data_done got %h exp %h", port_obs, pk(0, 0, 0, 0, 1, 0, 1, 0)); end
    checks++; if (d_rdata !== m_d_rdata) begin errors++; $display("FAIL simul_d_rdata got %h exp %h", d_rdata, m_d_rdata); end
    memory_response = 0; d_req = 0;
    tick;
    checks++; if (port_obs !== '0) begin errors++; $display("FAIL simul_gap_idle got %h exp 0", port_obs); end
    tick;
    checks++; if (port_obs !== pk(32'h44, 1, 0, 0, 1, 0, 0, 0)) begin errors++; $display("FAIL simul_fetch_second got %h exp %h", port_obs, pk(32'h44, 1, 0, 0, 1, 0, 0, 0)); end
    memory_response = 1; memory_read_val = 32'h33334444;
    tick;
    m_if_rdata = 32'h33334444;
    checks++; if (port_obs !== pk(0, 0, 0, 0, 1, 1, 0, 0)) begin errors++; $display("FAIL simul_fetch_done got %h exp %h", port_obs, pk(0, 0, 0, 0, 1, 1, 0, 0)); end
    checks++; if ({if_rdata, d_rdata} !== {m_if_rdata, m_d_rdata}) begin errors++; $display("FAIL simul_rdata got %h exp %h", {if_rdata, d_rdata}, {m_if_rdata, m_d_rdata}); end
    if_req = 0; memory_response = 0;
    tick;
  endtask

  task automatic test_write;
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
    tick;
    checks++; if (port_obs !== pk(32'h20, 0, 1, 32'hDEADBEEF, 1, 0, 0, 0)) begin errors++; $display("FAIL write_access got %h exp %h", port_obs, pk(32'h20, 0, 1, 32'hDEADBEEF, 1, 0, 0, 0)); end
    memory_response = 1; memory_read_val = 32'hFFFF0000;
    tick;
    checks++; if (port_obs !== pk(0, 0, 0, 0, 1, 0, 1, 0)) begin errors++; $display("FAIL write_done got %h exp %h", port_obs, pk(0, 0, 0, 0, 1, 0, 1, 0)); end
    checks++; if (d_rdata !== m_d_rdata) begin errors++; $display("FAIL write_rdata_kept got %h exp %h", d_rdata, m_d_rdata); end
    d_req = 0; d_we = 0; memory_response = 0;
    tick;
    checks++; if (port_obs !== '0) begin errors++; $display("FAIL write_idle got %h exp 0", port_obs); end
  endtask

  task automatic test_held_request;
    int n;
    int nd;
    if_req = 1; if_addr = 32'h80; memory_read_val = 32'h0BADF00D;
    n = 0; nd = 0;
    for (int i = 0; i < 20; i++) begin
      memory_response = memory_rden;
      tick;
      if (if_done) n++;
      if (d_done) nd++;
    end
    checks++; if (n !== 1 || nd !== 0) begin errors++; $display("FAIL held_single_fetch got %0d/%0d exp 1/0", n, nd); end
    if_req = 0; memory_response = 0;
    tick;
    if_req = 1; n = 0;
    for (int i = 0; i < 10; i++) begin
      memory_response = memory_rden;
      tick;
      if (if_done) n++;
    end
    checks++; if (n !== 1) begin errors++; $display("FAIL held_rearm_fetch got %0d exp 1", n); end
    m_if_rdata = 32'h0BADF00D;
    checks++; if (if_rdata !== m_if_rdata) begin errors++; $display("FAIL held_rdata got %h exp %h", if_rdata, m_if_rdata); end
    if_req = 0; memory_response = 0;
    tick;
  endtask

  task automatic test_timeout;
    if_req = 1; if_addr = 32'h100; memory_response = 0;
    tick;
    for (int unsigned c = 1; c <= 4; c++) begin
      checks++; if (port_obs !== pk(32'h100, 1, 0, 0, 1, 0, 0, 0)) begin errors++; $display("FAIL timeout_access c%0d got %h exp %h", c, port_obs, pk(32'h100, 1, 0, 0, 1, 0, 0, 0)); end
      tick;
    end
    m_if_rdata = '0;
    checks++; if (port_obs !== pk(0, 0, 0, 0, 1, 1, 0, 1)) begin errors++; $display("FAIL timeout_done got %h exp %h", port_obs, pk(0, 0, 0, 0, 1, 1, 0, 1)); end
    checks++; if (if_rdata !== m_if_rdata) begin errors++; $display("FAIL timeout_rdata got %h exp 0", if_rdata); end
    if_req = 0;
    tick;
    checks++; if (port_obs !== '0) begin errors++; $display("FAIL timeout_idle got %h exp 0", port_obs); end
    if_req = 1; if_addr = 32'h104;
    tick;
    checks++; if (port_obs !== pk(32'h104, 1, 0, 0, 1, 0, 0, 0)) begin errors++; $display("FAIL timeout_next_access got %h exp %h", port_obs, pk(32'h104, 1, 0, 0, 1, 0, 0, 0)); end
    memory_response = 1; memory_read_val = 32'h5;
    tick;
    m_if_rdata = 32'h5;
    checks++; if (port_obs !== pk(0, 0, 0, 0, 1, 1, 0, 0)) begin errors++; $display("FAIL timeout_next_done got %h exp %h", port_obs, pk(0, 0, 0, 0, 1, 1, 0, 0)); end
    checks++; if (if_rdata !== m_if_rdata) begin errors++; $display("FAIL timeout_next_rdata got %h exp %h", if_rdata, m_if_rdata); end
    if_req = 0; memory_response = 0;
    tick;
  endtask

  task automatic test_reset_mid_access;
    d_req = 1; d_we = 0; d_addr = 32'h200;
    tick;
    tick;
    checks++; if (port_obs !== pk(32'h200, 1, 0, 0, 1, 0, 0, 0)) begin errors++; $display("FAIL rst_mid_access got %h exp %h", port_obs, pk(32'h200, 1, 0, 0, 1, 0, 0, 0)); end
    reset = 1;
    tick;
    m_if_rdata = '0; m_d_rdata = '0;
    checks++; if ({port_obs, if_rdata, d_rdata} !== 134'd0) begin errors++; $display("FAIL rst_mid_outputs got %h exp 0", {port_obs, if_rdata, d_rdata}); end
    reset = 0; d_req = 0; memory_response = 1; memory_read_val = 32'hABCD;
    tick;
    checks++; if ({port_obs, d_rdata} !== 102'd0) begin errors++; $display("FAIL rst_stray_resp got %h exp 0", {port_obs, d_rdata}); end
    memory_response = 0;
    tick;
    checks++; if (port_obs !== '0) begin errors++; $display("FAIL rst_no_done got %h exp 0", port_obs); end
    d_req = 1; d_addr = 32'h204;
    tick;
    checks++; if (port_obs !== pk(32'h204, 1, 0, 0, 1, 0, 0, 0)) begin errors++; $display("FAIL rst_new_access got %h exp %h", port_obs, pk(32'h204, 1, 0, 0, 1, 0, 0, 0)); end
    memory_response = 1; memory_read_val = 32'h77;
    tick;
    m_d_rdata = 32'h77;
    checks++; if (port_obs !== pk(0, 0, 0, 0, 1, 0, 1, 0)) begin errors++; $display("FAIL rst_new_done got %h exp %h", port_obs, pk(0, 0, 0, 0, 1, 0, 1, 0)); end
    checks++; if (d_rdata !== m_d_rdata) begin errors++; $display("FAIL rst_new_rdata got %h exp %h", d_rdata, m_d_rdata); end
    d_req = 0; memory_response = 0;
    tick;
  endtask

  // Transaction-level model: winner by priority, latency L gives done at
  // cycle min(L,4)+1, timeout zeroes the owner's word, writes keep it.
  task automatic test_random;
    for (int unsigned it = 0; it < 60; it++) begin
      logic want_if, want_d, d_win, we, exp_err;
      logic [31:0] addr, wv, rv;
      int unsigned l, a_cyc;
      want_if = 1'($urandom % 2); want_d = 1'($urandom % 2);
      if (!want_if && !want_d) want_if = 1;
      if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom % 2);
      d_win = want_d;
      we    = d_win & d_we;
      addr  = d_win ? d_addr : if_addr;
      wv    = we ? d_wdata : 32'd0;
      l     = $urandom_range(1, 6);
      a_cyc = (l <= 4) ? l : 4;
      exp_err = (l > 4);
      rv    = $urandom;
      if_req = want_if; d_req = want_d;
      memory_response = 1'($urandom % 2);
      tick;
      if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom % 2);
      for (int unsigned c = 1; c <= a_cyc; c++) begin
        checks++; if (port_obs !== pk(addr, ~we, we, wv, 1, 0, 0, 0)) begin errors++; $display("FAIL rand_access it%0d c%0d got %h exp %h", it, c, port_obs, pk(addr, ~we, we, wv, 1, 0, 0, 0)); end
        memory_response = (c == l);
        memory_read_val = (c == l) ? rv : $urandom;
        tick;
      end
      if (exp_err) begin
        if (d_win) m_d_rdata = '0; else m_if_rdata = '0;
      end else if (!we) begin
        if (d_win) m_d_rdata = rv; else m_if_rdata = rv;
      end
      checks++; if (port_obs !== pk(0, 0, 0, 0, 1, ~d_win, d_win, exp_err)) begin errors++; $display("FAIL rand_done it%0d got %h exp %h", it, port_obs, pk(0, 0, 0, 0, 1, ~d_win, d_win, exp_err)); end
      checks++; if ({if_rdata, d_rdata} !== {m_if_rdata, m_d_rdata}) begin errors++; $display("FAIL rand_rdata it%0d got %h exp %h", it, {if_rdata, d_rdata}, {m_if_rdata, m_d_rdata}); end
      if_req = 0; d_req = 0;
      memory_response = 1'($urandom % 2);
      tick;
      checks++; if (port_obs !== '0) begin errors++; $display("FAIL rand_idle it%0d got %h exp 0", it, port_obs); end
      memory_response = 0;
    end
  endtask

  initial begin
    test_reset;
    test_fetch_read;
    test_simultaneous;
    test_write;
    test_held_request;
    test_timeout;
    test_reset_mid_access;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
